f36m_mult: RTL and testbench
============================

// Module: f36m_mult
// PURPOSE
//  Multiplies two elements of GF(3^{6M}) = GF(3^{2M})[rho]/(rho^3 - rho - B).
//  Operands are a2*rho^2 + a1*rho + a0, with each coefficient in GF(3^{2M}).
//  Uses 6-product Karatsuba with ONE time-shared f32m_mult. An FSM sequences the products.
//  Sits downstream of f32m_mult and consumes its products. Feeds the pairing Miller-loop accumulator and final exponentiation.
// PARAMETERS
//  NEG_B   0   reduction constant: 0 -> rho^3 = rho + 1, 1 -> rho^3 = rho - 1
// PORTS
//  clk    in   1        clock
//  reset  in   1        asynchronous, active-high; clears all state
//  start  in   1        one-cycle request; sampled only in IDLE
//  a      in   `W6+1    {a2,a1,a0}, each `W2+1 wide; sampled when start is accepted
//  b      in   `W6+1    {b2,b1,b0}; sampled when start is accepted
//  c      out  `W6+1    {c2,c1,c0} = a*b; registered
//  busy   out  1        high from the cycle after start is accepted until done rises
//  done   out  1        level; high while c is valid; cleared when the next start is accepted
// BEHAVIOUR
//  Reset values: c=0, done=0, busy=0, state=IDLE. The internal sub_rst to f32m_mult is 1 while reset is high.
//  Start accept: in IDLE with start=1, a and b are latched into internal regs, done<=0, go to ISSUE(k=0).
//    start outside IDLE is ignored, with no effect on the latched operands.
//  Products (k=0..5), taking in1/in2 operands:
//    v0=a0*b0, v1=a1*b1, v2=a2*b2
//    v3=(a0+a1)(b0+b1), v4=(a0+a2)(b0+b2), v5=(a1+a2)(b1+b2)
//  ISSUE(k): drive in1/in2 for product k; sub_rst=1 for exactly this cycle. Next state is WAIT(k).
//  WAIT(k): hold in1/in2 stable; sub_rst=0.
//    When f32m_mult done=1, latch its c into v[k].
//    Then go to ISSUE(k+1), or to COMB if k=5.
//    Sub-done is already 0 on the first WAIT cycle because the sub-block clears it on the sub_rst edge.
//  COMB (1 cycle): register c from the combine logic; done<=1, busy<=0; return to IDLE.
//  Combine (all arithmetic in GF(3^{2M}) via f32m_add/sub/neg; s=+1 when NEG_B=0, s=-1 when NEG_B=1):
//    t0=v0; t1=v3-v0-v1; t2=v4-v0-v2+v1; t3=v5-v1-v2; t4=v2
//    c0=t0+s*t3; c1=t1+t3+s*t4; c2=t2+t4
//  Latency: start accept to done high = 6*(L32+1)+2 cycles, where L32 = f32m_mult reset-to-done latency.
//  Operand regs are private, so a and b may change freely after the accept cycle.
//  Reset mid-operation: everything returns to reset values immediately; the partial v[k] are discarded.
//    The next start runs normally.
//  start and done high in the same IDLE cycle: the start is accepted and done drops the next cycle.
//  Zero operands are not special-cased; they pass through the full sequence.
// STRUCTURE
//  Shared include (inc.v): `WIDTH, `W2, `W6 = 6*(`WIDTH+1)-1, and the f3m encoding of one (`F3M_ONE).
//    State encodings stay local (localparam).
//  Instances: f32m_mult (one, shared), f32m_mux6 (operand select over the 6 products).
//  Sub-module: f36m_kara_combine. It is purely combinational, maps v0..v5 to {c2,c1,c0}, and takes NEG_B.
// TESTING
//  1. a=1 (a0=ONE, others 0), b=random X -> c=X; done high at exactly 6*(L32+1)+2 cycles after start.
//  2. NEG_B=0: a=rho (a1=ONE), b=rho^2 (b2=ONE) -> c2=0, c1=ONE, c0=ONE. NEG_B=1 -> c0=-ONE, c1=ONE, c2=0.
//  3. a=0, b=random -> c=0; busy stays high for the full sequence.
//  4. start pulsed again at k=2 with different a and b -> ignored; c equals the first product; done rises once.
//  5. reset asserted mid-WAIT(3) -> c=0, done=0, busy=0 asynchronously.
//     The next start with 1000 random operand pairs matches the software model.
//  6. Back-to-back: start asserted in the same cycle done is high -> done drops next cycle; the second result is correct.

Source files
------------

// File: rtl/f36m_mult_pkg.sv
// Shared types and GF(3^M) / GF(3^2M) helpers for the f36m multiplier slice.
// GF(3^M) = GF(3)[x]/(x^5+2x+1), two bits per trit; GF(3^2M) uses i^2 = -1.
package f36m_mult_pkg;

   localparam int M     = 5;
   localparam int WIDTH = 2*M - 1;
   localparam int W2    = 2*(WIDTH+1) - 1;
   localparam int W6    = 6*(WIDTH+1) - 1;
   localparam int CW    = $clog2(M+1);

   typedef logic [1:0]     trit_t;
   typedef logic [WIDTH:0] f3m_t;
   typedef logic [W2:0]    f32m_t;
   typedef logic [W6:0]    f36m_t;

   localparam f3m_t F3M_ONE = f3m_t'(1);

   function automatic trit_t trit_add(trit_t x, trit_t y);
      logic [2:0] s;
      s = {1'b0, x} + {1'b0, y};
      return (s >= 3'd3) ? trit_t'(s - 3'd3) : s[1:0];
   endfunction

   function automatic trit_t trit_neg(trit_t x);
      return {x[0], x[1]};
   endfunction

   function automatic trit_t trit_mul(trit_t x, trit_t y);
      if (x == 2'd0 || y == 2'd0)
         return 2'd0;
      return (x == y) ? 2'd1 : 2'd2;
   endfunction

   function automatic f3m_t f3m_add(f3m_t x, f3m_t y);
      f3m_t r;
      for (int i = 0; i < M; i++)
         r[2*i +: 2] = trit_add(x[2*i +: 2], y[2*i +: 2]);
      return r;
   endfunction

   function automatic f3m_t f3m_neg(f3m_t x);
      f3m_t r;
      for (int i = 0; i < M; i++)
         r[2*i +: 2] = trit_neg(x[2*i +: 2]);
      return r;
   endfunction

   function automatic f3m_t f3m_sub(f3m_t x, f3m_t y);
      return f3m_add(x, f3m_neg(y));
   endfunction

   function automatic f3m_t f3m_scale(f3m_t x, trit_t t);
      f3m_t r;
      for (int i = 0; i < M; i++)
         r[2*i +: 2] = trit_mul(x[2*i +: 2], t);
      return r;
   endfunction

   // x * e, folding the top trit back with x^M = x + 2
   function automatic f3m_t f3m_mulx(f3m_t x);
      trit_t t;
      f3m_t  r;
      t = x[2*M-1 -: 2];
      r = {x[2*M-3:0], 2'b00};
      r[1:0] = trit_neg(t);
      r[3:2] = trit_add(r[3:2], t);
      return r;
   endfunction

   function automatic f32m_t f32m_add(f32m_t x, f32m_t y);
      return {f3m_add(x[W2:WIDTH+1], y[W2:WIDTH+1]),
              f3m_add(x[WIDTH:0], y[WIDTH:0])};
   endfunction

   function automatic f32m_t f32m_neg(f32m_t x);
      return {f3m_neg(x[W2:WIDTH+1]),
              f3m_neg(x[WIDTH:0])};
   endfunction

   function automatic f32m_t f32m_sub(f32m_t x, f32m_t y);
      return f32m_add(x, f32m_neg(y));
   endfunction

endpackage

// File: rtl/f32m_mult.sv
// Trit-serial GF(3^2M) multiplier, restarted by its reset input.
// Done rises M+1 cycles after the first cycle reset is high.
module f32m_mult
   import f36m_mult_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [W2:0] a,
   input  logic [W2:0] b,
   output logic [W2:0] c,
   output logic        done
);

   logic [CW-1:0] cnt;
   f3m_t          a_r, a_i, b_r, b_i;
   f3m_t          p_rr, p_ii, p_ri, p_ir;
   trit_t         t_r, t_i;

   assign a_r = a[WIDTH:0];
   assign a_i = a[W2:WIDTH+1];
   assign b_r = b[WIDTH:0];
   assign b_i = b[W2:WIDTH+1];

   // b is consumed most-significant trit first
   always_comb begin
      t_r = '0;
      t_i = '0;
      for (int i = 0; i < M; i++) begin
         if (cnt == CW'(M - 1 - i)) begin
            t_r = b_r[2*i +: 2];
            t_i = b_i[2*i +: 2];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt  <= '0;
         done <= 1'b0;
         p_rr <= '0;
         p_ii <= '0;
         p_ri <= '0;
         p_ir <= '0;
      end else if (!done) begin
         p_rr <= f3m_add(f3m_mulx(p_rr),
                         f3m_scale(a_r, t_r));
         p_ii <= f3m_add(f3m_mulx(p_ii),
                         f3m_scale(a_i, t_i));
         p_ri <= f3m_add(f3m_mulx(p_ri),
                         f3m_scale(a_r, t_i));
         p_ir <= f3m_add(f3m_mulx(p_ir),
                         f3m_scale(a_i, t_r));
         cnt  <= cnt + CW'(1);
         done <= (cnt == CW'(M - 1));
      end
   end

   assign c = {f3m_add(p_ri, p_ir),
               f3m_sub(p_rr, p_ii)};

endmodule

// File: rtl/f32m_mux6.sv
// Operand select for the six Karatsuba products of an f36m multiply.
module f32m_mux6
   import f36m_mult_pkg::*;
(
   input  logic [2:0]  k,
   input  logic [W6:0] a,
   input  logic [W6:0] b,
   output logic [W2:0] in1,
   output logic [W2:0] in2
);

   f32m_t a0, a1, a2;
   f32m_t b0, b1, b2;

   assign a0 = a[W2:0];
   assign a1 = a[2*W2+1:W2+1];
   assign a2 = a[W6:2*W2+2];
   assign b0 = b[W2:0];
   assign b1 = b[2*W2+1:W2+1];
   assign b2 = b[W6:2*W2+2];

   always_comb begin
      in1 = '0;
      in2 = '0;
      unique case (k)
         3'd0: begin
            in1 = a0;
            in2 = b0;
         end
         3'd1: begin
            in1 = a1;
            in2 = b1;
         end
         3'd2: begin
            in1 = a2;
            in2 = b2;
         end
         3'd3: begin
            in1 = f32m_add(a0, a1);
            in2 = f32m_add(b0, b1);
         end
         3'd4: begin
            in1 = f32m_add(a0, a2);
            in2 = f32m_add(b0, b2);
         end
         3'd5: begin
            in1 = f32m_add(a1, a2);
            in2 = f32m_add(b1, b2);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/f36m_kara_combine.sv
// Recombines the six products into {c2,c1,c0} modulo rho^3 - rho - B.
module f36m_kara_combine
   import f36m_mult_pkg::*;
#(
   parameter bit NEG_B = 1'b0
) (
   input  logic [W2:0] v0,
   input  logic [W2:0] v1,
   input  logic [W2:0] v2,
   input  logic [W2:0] v3,
   input  logic [W2:0] v4,
   input  logic [W2:0] v5,
   output logic [W6:0] c
);

   f32m_t t1, t2, t3;
   f32m_t c0, c1, c2;

   function automatic f32m_t by_b(f32m_t x);
      return NEG_B ? f32m_neg(x) : x;
   endfunction

   assign t1 = f32m_sub(f32m_sub(v3, v0), v1);
   assign t2 = f32m_add(f32m_sub(f32m_sub(v4, v0), v2), v1);
   assign t3 = f32m_sub(f32m_sub(v5, v1), v2);

   // rho^3 = rho + B and rho^4 = rho^2 + B*rho
   assign c0 = f32m_add(v0, by_b(t3));
   assign c1 = f32m_add(f32m_add(t1, t3), by_b(v2));
   assign c2 = f32m_add(t2, v2);

   assign c = {c2, c1, c0};

endmodule

// File: rtl/f36m_mult.sv
// GF(3^6M) multiplier: six Karatsuba products through one shared f32m_mult.
module f36m_mult
   import f36m_mult_pkg::*;
#(
   parameter bit NEG_B = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [W6:0] a,
   input  logic [W6:0] b,
   output logic [W6:0] c,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_COMB
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  k_q, k_d;
   f36m_t       a_q, b_q;
   f32m_t       v_q [6];
   logic        issue_q;
   logic        load, grab, fin;
   logic        sub_rst, sub_done;
   f32m_t       sub_c, in1, in2;
   f36m_t       comb_c;

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      load    = 1'b0;
      grab    = 1'b0;
      fin     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               load    = 1'b1;
               k_d     = 3'd0;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: state_d = S_WAIT;
         S_WAIT: begin
            if (sub_done) begin
               grab = 1'b1;
               if (k_q == 3'd5) begin
                  state_d = S_COMB;
               end else begin
                  k_d     = k_q + 3'd1;
                  state_d = S_ISSUE;
               end
            end
         end
         S_COMB: begin
            fin     = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         issue_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         c       <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         for (int i = 0; i < 6; i++)
            v_q[i] <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         issue_q <= (state_d == S_ISSUE);
         if (load) begin
            a_q  <= a;
            b_q  <= b;
            done <= 1'b0;
            busy <= 1'b1;
         end
         if (grab)
            v_q[k_q] <= sub_c;
         if (fin) begin
            c    <= comb_c;
            done <= 1'b1;
            busy <= 1'b0;
         end
      end
   end

   // registered issue flag keeps the restart pulse glitch-free
   assign sub_rst = reset | issue_q;

   f32m_mux6 u_mux (
      .k   (k_q),
      .a   (a_q),
      .b   (b_q),
      .in1 (in1),
      .in2 (in2)
   );

   f32m_mult u_mul (
      .clk   (clk),
      .reset (sub_rst),
      .a     (in1),
      .b     (in2),
      .c     (sub_c),
      .done  (sub_done)
   );

   f36m_kara_combine #(
      .NEG_B (NEG_B)
   ) u_comb (
      .v0 (v_q[0]),
      .v1 (v_q[1]),
      .v2 (v_q[2]),
      .v3 (v_q[3]),
      .v4 (v_q[4]),
      .v5 (v_q[5]),
      .c  (comb_c)
   );

endmodule

// File: tb/tb_f36m_mult.sv
// Random and directed checks of f36m_mult against a schoolbook GF(3^6M) model.
module tb_f36m_mult;

   localparam int M   = 5;
   localparam int L32 = M + 1;
   localparam int LAT = 6*(L32+1) + 2;

   logic        clk;
   logic        reset;
   logic        start;
   logic [59:0] a, b;
   logic [59:0] c0, c1;
   logic        busy0, busy1;
   logic        done0, done1;

   int checks;
   int errors;

   f36m_mult #(.NEG_B(1'b0)) u_dut0 (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .a     (a),
      .b     (b),
      .c     (c0),
      .busy  (busy0),
      .done  (done0)
   );

   f36m_mult #(.NEG_B(1'b1)) u_dut1 (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .a     (a),
      .b     (b),
      .c     (c1),
      .busy  (busy1),
      .done  (done1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   function automatic int tr(logic [9:0] x, int i);
      return int'(x[2*i +: 2]);
   endfunction

   function automatic logic [9:0] m_lin(logic [9:0] x,
                                        logic [9:0] y,
                                        int s);
      logic [9:0] r;
      for (int i = 0; i < M; i++)
         r[2*i +: 2] = 2'((tr(x, i) + s*tr(y, i)) % 3);
      return r;
   endfunction

   function automatic logic [9:0] m_mul(logic [9:0] x,
                                        logic [9:0] y);
      int p [9];
      logic [9:0] r;
      for (int i = 0; i < 9; i++) p[i] = 0;
      for (int i = 0; i < M; i++)
         for (int j = 0; j < M; j++)
            p[i+j] += tr(x, i) * tr(y, j);
      for (int d = 8; d >= M; d--) begin
         p[d-4] += p[d];
         p[d-5] += 2*p[d];
         p[d] = 0;
      end
      for (int i = 0; i < M; i++)
         r[2*i +: 2] = 2'(p[i] % 3);
      return r;
   endfunction

   function automatic logic [19:0] q_add(logic [19:0] x,
                                         logic [19:0] y,
                                         int s);
      return {m_lin(x[19:10], y[19:10], s),
              m_lin(x[9:0], y[9:0], s)};
   endfunction

   function automatic logic [19:0] q_mul(logic [19:0] x,
                                         logic [19:0] y);
      logic [9:0] re, im;
      re = m_lin(m_mul(x[9:0], y[9:0]),
                 m_mul(x[19:10], y[19:10]), 2);
      im = m_lin(m_mul(x[9:0], y[19:10]),
                 m_mul(x[19:10], y[9:0]), 1);
      return {im, re};
   endfunction

   function automatic logic [59:0] ref36(logic [59:0] x,
                                        logic [59:0] y,
                                        bit nb);
      logic [19:0] d [5];
      int sb;
      sb = nb ? 2 : 1;
      for (int n = 0; n < 5; n++) d[n] = '0;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            d[i+j] = q_add(d[i+j],
                           q_mul(x[20*i +: 20], y[20*j +: 20]), 1);
      d[2] = q_add(d[2], d[4], 1);
      d[1] = q_add(d[1], d[4], sb);
      d[1] = q_add(d[1], d[3], 1);
      d[0] = q_add(d[0], d[3], sb);
      return {d[2], d[1], d[0]};
   endfunction

   function automatic logic [59:0] rnd36();
      logic [59:0] r;
      for (int i = 0; i < 30; i++)
         r[2*i +: 2] = 2'($urandom_range(2, 0));
      return r;
   endfunction

   task automatic run_op(input logic [59:0] x,
                         input logic [59:0] y,
                         input int mid_at,
                         input int rst_at,
                         input bit chk_lat);
      int n;
      int lowb;
      int droph;
      logic [59:0] e0, e1;
      e0 = ref36(x, y, 1'b0);
      e1 = ref36(x, y, 1'b1);
      @(negedge clk);
      start = 1'b1;
      a = x;
      b = y;
      n = 0;
      lowb = 0;
      forever begin
         @(posedge clk);
         n++;
         #1;
         if (n == 1) begin
            start = 1'b0;
            a = rnd36();
            b = rnd36();
            chk("done_drop", {63'b0, done0}, 64'd0);
         end
         if (mid_at > 0 && n == mid_at) begin
            start = 1'b1;
            a = rnd36();
            b = rnd36();
         end
         if (mid_at > 0 && n == mid_at + 1)
            start = 1'b0;
         if (rst_at > 0 && n == rst_at) begin
            #2 reset = 1'b1;
            #1;
            chk("rst_c0", {4'b0, c0}, 64'd0);
            chk("rst_c1", {4'b0, c1}, 64'd0);
            chk("rst_done", {62'b0, done0, done1}, 64'd0);
            chk("rst_busy", {62'b0, busy0, busy1}, 64'd0);
            #3 reset = 1'b0;
            return;
         end
         if (done0)
            break;
         if (!busy0 || !busy1)
            lowb++;
         if (n >= 200) begin
            chk("done_timeout", {63'b0, done0}, 64'd1);
            return;
         end
      end
      if (chk_lat)
         chk("latency", 64'(n), 64'(LAT));
      chk("busy_hold", 64'(lowb), 64'd0);
      chk("busy_end", {62'b0, busy0, busy1}, 64'd0);
      chk("done1", {63'b0, done1}, 64'd1);
      chk("c_negb0", {4'b0, c0}, {4'b0, e0});
      chk("c_negb1", {4'b0, c1}, {4'b0, e1});
      if (mid_at > 0) begin
         droph = 0;
         repeat (5) begin
            @(posedge clk);
            #1;
            if (!done0 || busy0)
               droph++;
         end
         chk("done_once", 64'(droph), 64'd0);
      end
   endtask

   initial begin
      logic [59:0] x, y;
      checks = 0;
      errors = 0;
      reset = 1'b1;
      start = 1'b0;
      a = '0;
      b = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_c", {4'b0, c0}, 64'd0);
      chk("reset_flags", {60'b0, busy0, done0, busy1, done1}, 64'd0);
      @(negedge clk);
      reset = 1'b0;

      // multiply by one, with latency
      y = rnd36();
      run_op(60'h1, y, 0, 0, 1'b1);
      chk("one_x", {4'b0, c0}, {4'b0, y});
      chk("one_x_nb", {4'b0, c1}, {4'b0, y});

      // rho * rho^2, launched while done is still high
      x = 60'h1 << 20;
      y = 60'h1 << 40;
      run_op(x, y, 0, 0, 1'b0);
      chk("rho3_nb0", {4'b0, c0}, {4'b0, 20'h0, 20'h1, 20'h1});
      chk("rho3_nb1", {4'b0, c1}, {4'b0, 20'h0, 20'h1, 20'h2});

      // zero operand
      run_op(60'h0, rnd36(), 0, 0, 1'b1);
      chk("zero_c", {4'b0, c0}, 64'd0);

      // start pulsed during product 2
      run_op(rnd36(), rnd36(), 17, 0, 1'b1);

      // reset during the fourth product, then random traffic
      run_op(rnd36(), rnd36(), 0, 25, 1'b0);
      for (int i = 0; i < 1000; i++)
         run_op(rnd36(), rnd36(), 0, 0, (i < 4));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
